// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, bit positions and serializer state encoding for uart_tx_port
package uart_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVR    = 3;
  localparam int ST_IRQ_EN = 7;

  localparam int CTRL_OVR_CLR = 3;
  localparam int CTRL_IRQ_EN  = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic logic [7:0] pack_status(input logic irq_en, input logic ovr,
                                             input logic empty, input logic full,
                                             input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[ST_IRQ_EN] = irq_en;
    s[ST_OVR]    = ovr;
    s[ST_EMPTY]  = empty;
    s[ST_FULL]   = full;
    s[ST_BUSY]   = busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_port_sync_fifo.sv
// rtl/uart_tx_port_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and show-ahead read data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - I/O-mapped 8N1 transmitter: bus decode, CSRs, TX FIFO and baud serializer
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       tx,
  output logic       irq
);

  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);

  tx_state_e   state_q;
  logic        tx_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic [15:0] baud_q;
  logic        wr_act_q, ovr_q, irq_en_q, irq_q;
  logic [7:0]  dout_q, dout_d;

  logic       wr_act, rd_act, wr_ev, data_wr, ctrl_wr;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       baud_done, busy;

  assign wr_act    = ~cs_n & ~wr_n;
  assign rd_act    = ~cs_n & ~rd_n;
  assign wr_ev     = wr_act & ~wr_act_q;
  assign data_wr   = wr_ev & (a0 == REG_DATA);
  assign ctrl_wr   = wr_ev & (a0 == REG_CTRL);
  assign fifo_push = data_wr & ~fifo_full;
  assign baud_done = (baud_q == 16'd0);
  assign busy      = (state_q != IDLE);
  assign fifo_pop  = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & baud_done));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      baud_q    <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= START;
            tx_q    <= 1'b0;
            shift_q <= fifo_rdata;
            baud_q  <= BAUD_LOAD;
          end
        end
        START: begin
          if (baud_done) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= 3'd0;
            baud_q    <= BAUD_LOAD;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= BAUD_LOAD;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            // Chain straight into the next start bit so queued bytes leave with no idle gap.
            if (!fifo_empty) begin
              state_q <= START;
              tx_q    <= 1'b0;
              shift_q <= fifo_rdata;
              baud_q  <= BAUD_LOAD;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (rd_act) dout_d = (a0 == REG_CTRL) ? pack_status(irq_en_q, ovr_q, fifo_empty, fifo_full, busy)
                                          : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_act_q <= 1'b0;
      ovr_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      dout_q   <= 8'h00;
    end else begin
      wr_act_q <= wr_act;
      dout_q   <= dout_d;
      irq_q    <= irq_en_q & fifo_empty & ~busy;
      if (data_wr && fifo_full) ovr_q <= 1'b1;
      else if (ctrl_wr && din[CTRL_OVR_CLR]) ovr_q <= 1'b0;
      if (ctrl_wr) irq_en_q <= din[CTRL_IRQ_EN];
    end
  end

  assign dout = dout_q;
  assign tx   = tx_q;
  assign irq  = irq_q;

endmodule
